// File: rtl/decim_fir_mac_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : decim_fir_mac_if                                               |
// | Brief   : Sample, coefficient-write and status bundle of decim_fir_mac.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface decim_fir_mac_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS    = 8
);
  localparam int TAP_AW = $clog2(NUM_TAPS);

  logic                   enable;
  logic                   valid_in;
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   coeff_wr_en;
  logic [TAP_AW-1:0]      coeff_addr;
  logic [COEFF_WIDTH-1:0] coeff_wdata;
  logic                   clear_overrun;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   valid_out;
  logic                   busy;
  logic                   overrun;

  modport master (
    output enable, valid_in, data_in, coeff_wr_en, coeff_addr, coeff_wdata, clear_overrun,
    input  data_out, valid_out, busy, overrun
  );

  modport slave (
    input  enable, valid_in, data_in, coeff_wr_en, coeff_addr, coeff_wdata, clear_overrun,
    output data_out, valid_out, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/decim_fir_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : decim_fir_mac                                                  |
// | Brief   : Single-multiplier time-multiplexed FIR on a decimated stream;  |
// |           define DECIM_FIR_SAT_EN to saturate instead of wrap the output. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module decim_fir_mac #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS    = 8,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS)
) (
  input  logic           clk_in,
  input  logic           rst_n,
  decim_fir_mac_if.slave bus
);
  localparam int TAP_AW = $clog2(NUM_TAPS);
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam logic [TAP_AW-1:0] LAST_TAP = TAP_AW'(NUM_TAPS - 1);
  localparam logic signed [COEFF_WIDTH-1:0] COEFF_ONE = {1'b0, {(COEFF_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [TAP_AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [TAP_AW-1:0]             k_q, k_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                          overrun_q, overrun_d;
  logic signed [DATA_WIDTH-1:0]  dline_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  dline_d [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] coeff_q [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] coeff_d [NUM_TAPS];

  logic [TAP_AW-1:0]             tap_idx;
  logic signed [DATA_WIDTH-1:0]  tap_sample;
  logic signed [COEFF_WIDTH-1:0] tap_coeff;
  logic signed [PROD_W-1:0]      product;
  logic signed [ACC_WIDTH-1:0]   mac_sum;
  logic signed [DATA_WIDTH-1:0]  result;

  // wr_ptr already points past the newest sample once MAC starts.
  always_comb begin
    tap_idx    = wr_ptr_q - TAP_AW'(1) - k_q;
    tap_sample = dline_q[tap_idx];
    tap_coeff  = coeff_q[k_q];
    product    = $signed({{COEFF_WIDTH{tap_sample[DATA_WIDTH-1]}}, tap_sample})
               * $signed({{DATA_WIDTH{tap_coeff[COEFF_WIDTH-1]}}, tap_coeff});
    mac_sum    = acc_q + $signed({{(ACC_WIDTH-PROD_W){product[PROD_W-1]}}, product});
  end

`ifdef DECIM_FIR_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0]  SAT_MAX  = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0]  SAT_MIN  = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] DOUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DOUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] shifted;

  always_comb begin
    shifted = mac_sum >>> (COEFF_WIDTH - 1);
    if (shifted > SAT_MAX) begin
      result = DOUT_MAX;
    end else if (shifted < SAT_MIN) begin
      result = DOUT_MIN;
    end else begin
      result = shifted[DATA_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    result = mac_sum[COEFF_WIDTH-1 +: DATA_WIDTH];
  end
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    k_d        = k_q;
    acc_d      = acc_q;
    data_out_d = data_out_q;
    dline_d    = dline_q;
    coeff_d    = coeff_q;
    overrun_d  = overrun_q & ~bus.clear_overrun;

    // A set wins over a simultaneous clear.
    if (bus.enable && bus.valid_in && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    if ((state_q == ST_IDLE) && bus.coeff_wr_en) begin
      coeff_d[bus.coeff_addr] = $signed(bus.coeff_wdata);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.enable && bus.valid_in) begin
          dline_d[wr_ptr_q] = $signed(bus.data_in);
          wr_ptr_d          = wr_ptr_q + TAP_AW'(1);
          acc_d             = '0;
          k_d               = '0;
          state_d           = ST_MAC;
        end
      end
      ST_MAC: begin
        if (bus.enable) begin
          acc_d = mac_sum;
          k_d   = k_q + TAP_AW'(1);
          if (k_q == LAST_TAP) begin
            // Final sum is folded into data_out here so it is stable for the OUT cycle.
            data_out_d = result;
            state_d    = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (bus.enable) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      data_out_q <= '0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        dline_q[i] <= '0;
        coeff_q[i] <= (i == 0) ? COEFF_ONE : '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
      overrun_q  <= overrun_d;
      dline_q    <= dline_d;
      coeff_q    <= coeff_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = (state_q == ST_OUT) && bus.enable;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.overrun   = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_decim_fir_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_decim_fir_mac                                               |
// | Brief   : Directed and random checks of decim_fir_mac against a          |
// |           sum-of-products reference model.                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_decim_fir_mac;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NT = 8;
  localparam int AW = $clog2(NT);

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  decim_fir_mac_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT)) bus ();

  decim_fir_mac #(
    .DATA_WIDTH (DW),
    .COEFF_WIDTH(CW),
    .NUM_TAPS   (NT),
    .ACC_WIDTH  (DW + CW + AW)
  ) dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference: newest sample at index 0, coefficients indexed by tap.
  logic signed [DW-1:0] hist [$];
  logic signed [CW-1:0] cm [NT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (NT) hist.push_back('0);
    for (int k = 0; k < NT; k++) cm[k] = '0;
    cm[0] = 16'sh7FFF;
  endtask

  function automatic logic [DW-1:0] model_out();
    longint acc;
    longint maxv;
    longint minv;
    acc  = 0;
    maxv = (64'sd1 <<< (DW - 1)) - 1;
    minv = -(64'sd1 <<< (DW - 1));
    for (int k = 0; k < NT; k++) acc += longint'(hist[k]) * longint'(cm[k]);
    acc = acc >>> (CW - 1);
`ifdef DECIM_FIR_SAT_EN
    if (acc > maxv) acc = maxv;
    else if (acc < minv) acc = minv;
`else
    if (maxv < minv) acc = 0;
`endif
    return acc[DW-1:0];
  endfunction

  task automatic write_coeff(input int addr, input logic [CW-1:0] val);
    bus.coeff_wr_en = 1'b1;
    bus.coeff_addr  = AW'(addr);
    bus.coeff_wdata = val;
    tick();
    bus.coeff_wr_en = 1'b0;
    cm[addr] = $signed(val);
  endtask

  task automatic send(input logic [DW-1:0] x);
    bus.data_in  = x;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    hist.push_front($signed(x));
    void'(hist.pop_back());
  endtask

  // Waits for the pulse, checks its distance in edges, value and width; ends in IDLE.
  task automatic expect_out(input int exp_ticks, input logic [DW-1:0] exp, input string tag);
    int n;
    n = 0;
    while (bus.valid_out !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, 32'(bus.valid_out), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(exp_ticks));
    check({tag, "_data"}, 32'(bus.data_out), 32'(exp));
    tick();
    check({tag, "_pulse"}, 32'(bus.valid_out), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] x;
    int hits;

    bus.enable        = 1'b1;
    bus.valid_in      = 1'b0;
    bus.data_in       = '0;
    bus.coeff_wr_en   = 1'b0;
    bus.coeff_addr    = '0;
    bus.coeff_wdata   = '0;
    bus.clear_overrun = 1'b0;
    model_reset();

    // Reset values
    tick();
    tick();
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // Default coefficients: near pass-through; pulse NT edges after the accept edge
    send(16'h4000);
    check("pass_busy", 32'(bus.busy), 32'd1);
    expect_out(NT, 16'h3FFF, "pass");

    // Impulse response
    do_reset();
    for (int k = 0; k < NT; k++) write_coeff(k, 16'(16'h0200 * (k + 1)));
    for (int i = 0; i < NT; i++) begin
      send((i == 0) ? 16'h4000 : 16'h0000);
      expect_out(NT, 16'(16'h0100 * (i + 1)), "impulse");
    end

    // Positive full scale
    for (int k = 0; k < NT; k++) write_coeff(k, 16'h7FFF);
    for (int i = 0; i < NT; i++) begin
      send(16'h7FFF);
      if (i == NT - 1) begin
`ifdef DECIM_FIR_SAT_EN
        check("satpos_const", 32'(model_out()), 32'h7FFF);
`else
        check("wrappos_const", 32'(model_out()), 32'hFFF0);
`endif
      end
      expect_out(NT, model_out(), "fullpos");
    end

    // Negative full scale
    for (int i = 0; i < NT; i++) begin
      send(16'h8000);
      if (i == NT - 1) begin
`ifdef DECIM_FIR_SAT_EN
        check("satneg_const", 32'(model_out()), 32'h8000);
`else
        check("wrapneg_const", 32'(model_out()), 32'h0008);
`endif
      end
      expect_out(NT, model_out(), "fullneg");
    end

    // Random samples, coefficients and gaps
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(3) == 0) write_coeff($urandom_range(NT - 1), CW'($urandom));
      repeat ($urandom_range(3)) tick();
      send(DW'($urandom));
      expect_out(NT, model_out(), "rand");
    end

    // Overrun: dropped sample and discarded busy coefficient write
    send(DW'($urandom));
    tick();
    tick();
    bus.valid_in    = 1'b1;
    bus.data_in     = DW'($urandom);
    bus.coeff_wr_en = 1'b1;
    bus.coeff_addr  = '0;
    bus.coeff_wdata = CW'($urandom);
    tick();
    bus.valid_in    = 1'b0;
    bus.coeff_wr_en = 1'b0;
    check("ovr_set", 32'(bus.overrun), 32'd1);
    expect_out(NT - 3, model_out(), "ovr_first");
    send(DW'($urandom));
    expect_out(NT, model_out(), "ovr_after");
    check("ovr_sticky", 32'(bus.overrun), 32'd1);
    bus.clear_overrun = 1'b1;
    tick();
    bus.clear_overrun = 1'b0;
    check("ovr_clear", 32'(bus.overrun), 32'd0);

    // Set and clear in the same cycle: set wins
    send(DW'($urandom));
    tick();
    bus.valid_in      = 1'b1;
    bus.data_in       = DW'($urandom);
    bus.clear_overrun = 1'b1;
    tick();
    bus.valid_in      = 1'b0;
    bus.clear_overrun = 1'b0;
    check("ovr_setclr", 32'(bus.overrun), 32'd1);
    expect_out(NT - 2, model_out(), "ovr_setclr");
    bus.clear_overrun = 1'b1;
    tick();
    bus.clear_overrun = 1'b0;
    check("ovr_clear2", 32'(bus.overrun), 32'd0);

    // Enable stall mid-MAC with valid_in held high: 5 edges extra latency
    send(DW'($urandom));
    repeat (3) tick();
    bus.enable   = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = DW'($urandom);
    repeat (5) tick();
    bus.valid_in = 1'b0;
    bus.enable   = 1'b1;
    check("stall_no_ovr", 32'(bus.overrun), 32'd0);
    expect_out(NT + 5 - 8, model_out(), "stall");

    // Enable stall during OUT: pulse deferred to the first enabled OUT cycle
    send(DW'($urandom));
    repeat (NT) tick();
    check("outstall_pre", 32'(bus.valid_out), 32'd1);
    bus.enable = 1'b0;
    #1;
    check("outstall_masked", 32'(bus.valid_out), 32'd0);
    repeat (3) tick();
    check("outstall_hold", 32'(bus.valid_out), 32'd0);
    check("outstall_busy", 32'(bus.busy), 32'd1);
    bus.enable = 1'b1;
    #1;
    check("outstall_pulse", 32'(bus.valid_out), 32'd1);
    check("outstall_data", 32'(bus.data_out), 32'(model_out()));
    tick();
    check("outstall_done", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-MAC
    send(DW'($urandom));
    tick();
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    tick();
    check("midrst_pre_ovr", 32'(bus.overrun), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", 32'(bus.data_out), 32'd0);
    check("midrst_valid_out", 32'(bus.valid_out), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_overrun", 32'(bus.overrun), 32'd0);
    tick();
    rst_n = 1'b1;
    model_reset();
    hits = 0;
    repeat (12) begin
      tick();
      if (bus.valid_out === 1'b1) hits++;
    end
    check("midrst_no_pulse", 32'(hits), 32'd0);
    for (int k = 0; k < NT; k++) write_coeff(k, 16'h7FFF);
    x = DW'($urandom);
    send(x);
    expect_out(NT, model_out(), "midrst_zero_dline");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
